// File: rtl/vertex_transform_if.sv
// ---------------------------------------------------------------------------
// vertex_transform_if
// Bundles the vertex-in and vertex-out handshake channels of vertex_transform.
//
// Handshake: a transfer happens on a rising Clk edge where valid and ready are
// both high. A source holds its payload stable while valid is high and ready is
// low. Ready may be raised without valid.
//
// Signals
//   matrix     4x4 matrix, row-major, element m[4*r+c], signed Q2.12
//   vx/vy/vz   source vertex, signed Q8.8 (w is implicitly 1.0)
//   in_valid   producer offers a vertex/matrix pair
//   in_ready   transformer can accept a vertex
//   ox/oy/oz   transformed vertex, signed Q8.8
//   sat        at least one of ox/oy/oz was clamped
//   out_valid  ox/oy/oz/sat are valid
//   out_ready  consumer accepts the result
//
// Modports: master = producer/consumer side, slave = the transformer.
// ---------------------------------------------------------------------------
interface vertex_transform_if #(
    parameter int VW = 16,
    parameter int MW = 14
);
    logic [15:0][MW-1:0] matrix;
    logic [VW-1:0]       vx;
    logic [VW-1:0]       vy;
    logic [VW-1:0]       vz;
    logic                in_valid;
    logic                in_ready;
    logic [VW-1:0]       ox;
    logic [VW-1:0]       oy;
    logic [VW-1:0]       oz;
    logic                sat;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output matrix, vx, vy, vz, in_valid, out_ready,
        input  in_ready, ox, oy, oz, sat, out_valid
    );

    modport slave (
        input  matrix, vx, vy, vz, in_valid, out_ready,
        output in_ready, ox, oy, oz, sat, out_valid
    );
endinterface

// File: rtl/vertex_transform.sv
// ---------------------------------------------------------------------------
// vertex_transform
// Multiplies a Q8.8 vertex (x, y, z, 1.0) by the top three rows of a Q2.12
// 4x4 matrix using one multiplier, one product per cycle (12 MAC cycles).
// Each row result is floor-shifted back to Q8.8 and clamped to the signed
// VW range; sat records any clamp.
//
// Ports
//   Clk      single clock, rising edge
//   Reset    synchronous, active-high
//   bus      vertex_transform_if.slave (vertex in / result out handshakes)
//   state_o  current FSM state (0 IDLE, 1 MAC, 2 DONE) for observation
// ---------------------------------------------------------------------------
module vertex_transform #(
    parameter int VW = 16,
    parameter int MW = 14
) (
    input  logic                 Clk,
    input  logic                 Reset,
    vertex_transform_if.slave    bus,
    output logic [1:0]           state_o
);
    // Four products of MW+VW bits plus two bits of headroom never overflow.
    localparam int PW = MW + VW;
    localparam int AW = (PW + 2 > 32) ? PW + 2 : 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [15:0][MW-1:0]        mat_q;
    logic [2:0][VW-1:0]         vec_q;
    logic signed [AW-1:0]       acc_q;
    logic [1:0]                 r_q;
    logic [1:0]                 c_q;
    logic [VW-1:0]              ox_q, oy_q, oz_q;
    logic                       sat_q;

    logic                       accept;
    logic signed [MW-1:0]       elem;
    logic signed [VW-1:0]       v_sel;
    logic signed [PW-1:0]       prod;
    logic signed [AW-1:0]       prod_ext;
    logic signed [AW-1:0]       sum;
    logic signed [AW-1:0]       shifted;
    logic [AW-VW:0]             hi;
    logic                       ovf;
    logic [VW-1:0]              row_val;

    assign accept = (state_q == IDLE) && bus.in_valid;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = MAC;
            MAC:     if (r_q == 2'd2 && c_q == 2'd3) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE:    bus.in_ready  = 1'b1;
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state_q;

    // ---------------- MAC datapath ----------------
    // {r,c} concatenated is exactly the row-major element index 4r+c.
    assign elem = $signed(mat_q[{r_q, c_q}]);

    always_comb begin
        v_sel = VW'(256);   // w = 1.0 in Q8.8
        case (c_q)
            2'd0:    v_sel = $signed(vec_q[0]);
            2'd1:    v_sel = $signed(vec_q[1]);
            2'd2:    v_sel = $signed(vec_q[2]);
            default: ;
        endcase
    end

    assign prod     = elem * v_sel;
    assign prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    assign sum      = acc_q + prod_ext;
    // Q10.20 -> Q8.8: arithmetic shift floors toward minus infinity.
    assign shifted  = sum >>> 12;

    // In range only when every bit from the VW sign bit upward agrees.
    assign hi      = shifted[AW-1:VW-1];
    assign ovf     = !((&hi) || !(|hi));
    assign row_val = ovf ? (shifted[AW-1] ? {1'b1, {(VW-1){1'b0}}}
                                          : {1'b0, {(VW-1){1'b1}}})
                         : shifted[VW-1:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            mat_q <= '0;
            vec_q <= '0;
            acc_q <= '0;
            r_q   <= '0;
            c_q   <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
            oz_q  <= '0;
            sat_q <= 1'b0;
        end else if (accept) begin
            mat_q <= bus.matrix;
            vec_q <= {bus.vz, bus.vy, bus.vx};
            acc_q <= '0;
            r_q   <= '0;
            c_q   <= '0;
            sat_q <= 1'b0;
        end else if (state_q == MAC) begin
            if (c_q == 2'd3) begin
                case (r_q)
                    2'd0:    ox_q <= row_val;
                    2'd1:    oy_q <= row_val;
                    default: oz_q <= row_val;
                endcase
                sat_q <= sat_q | ovf;
                acc_q <= '0;
                r_q   <= r_q + 2'd1;
                c_q   <= '0;
            end else begin
                acc_q <= sum;
                c_q   <= c_q + 2'd1;
            end
        end
    end

    assign bus.ox  = ox_q;
    assign bus.oy  = oy_q;
    assign bus.oz  = oz_q;
    assign bus.sat = sat_q;
endmodule

// File: tb/tb_vertex_transform.sv
module tb_vertex_transform;
  typedef logic [15:0][13:0] mat_t;
  typedef struct {
    mat_t        m;
    logic [15:0] x, y, z;
    logic [15:0] ex, ey, ez;
    logic        es;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  int         acc_cyc = 0;
  logic [48:0] exp_q[$];

  vertex_transform_if #(.VW(16), .MW(14)) bus ();

  vertex_transform #(.VW(16), .MW(14)) dut (
    .Clk     (clk),
    .Reset   (rst),
    .bus     (bus),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic mat_t ident();
    mat_t m = '0;
    m[0]  = 14'h1000;
    m[5]  = 14'h1000;
    m[10] = 14'h1000;
    m[15] = 14'h1000;
    return m;
  endfunction

  // Reference: full-precision dot products, floor shift, clamp.
  function automatic logic [48:0] model(input mat_t m, input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
    longint v[4];
    logic [15:0] o[3];
    logic s = 1'b0;
    v[0] = longint'($signed(x));
    v[1] = longint'($signed(y));
    v[2] = longint'($signed(z));
    v[3] = 256;
    for (int r = 0; r < 3; r++) begin
      longint acc = 0;
      for (int c = 0; c < 4; c++) acc += longint'($signed(m[4*r+c])) * v[c];
      acc = acc >>> 12;
      if (acc > 32767) begin
        o[r] = 16'h7FFF; s = 1'b1;
      end else if (acc < -32768) begin
        o[r] = 16'h8000; s = 1'b1;
      end else begin
        o[r] = acc[15:0];
      end
    end
    return {o[0], o[1], o[2], s};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input mat_t m, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] z, input logic [48:0] exp);
    bus.matrix   = m;
    bus.vx       = x;
    bus.vy       = y;
    bus.vz       = z;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 30 && !bus.in_ready; t++) @(negedge clk);
    if (!bus.in_ready) begin
      check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    acc_cyc = cyc + 1;
    @(negedge clk);
    // Scramble inputs after acceptance; the result must not change.
    bus.in_valid = 1'b0;
    for (int i = 0; i < 16; i++) bus.matrix[i] = 14'($urandom_range(0, 16383));
    bus.vx = 16'($urandom_range(0, 65535));
    bus.vy = 16'($urandom_range(0, 65535));
    bus.vz = 16'($urandom_range(0, 65535));
  endtask

  // Waits for the result, holds out_ready low for 'hold' cycles, then consumes.
  task automatic collect(input int hold);
    logic [48:0] exp;
    bus.out_ready = (hold == 0);
    for (int t = 0; t < 40 && !bus.out_valid; t++) @(negedge clk);
    if (!bus.out_valid) begin
      check("out_valid_timeout", 64'(bus.out_valid), 64'd1);
      bus.out_ready = 1'b1;
      return;
    end
    check("latency", 64'(cyc - acc_cyc), 64'd12);
    if (exp_q.size() == 0) begin
      check("unexpected_output", 64'(exp_q.size()), 64'd1);
      bus.out_ready = 1'b1;
      return;
    end
    exp = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      check("hold_out_valid", 64'(bus.out_valid), 64'd1);
      check("hold_in_ready", 64'(bus.in_ready), 64'd0);
      check("hold_data", 64'({bus.ox, bus.oy, bus.oz, bus.sat}), 64'(exp));
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    check("result", 64'({bus.ox, bus.oy, bus.oz, bus.sat}), 64'(exp));
    @(negedge clk);
    check("post_out_valid", 64'(bus.out_valid), 64'd0);
    check("post_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[6];

  initial begin
    mat_t m;
    int   prev;

    // Table: identity, translation, rotation, saturation (+/-), floor.
    tbl[0].m = ident();
    tbl[0].x = 16'h0100; tbl[0].y = 16'h0200; tbl[0].z = 16'hFF00;
    tbl[0].ex = 16'h0100; tbl[0].ey = 16'h0200; tbl[0].ez = 16'hFF00; tbl[0].es = 1'b0;

    m = ident(); m[3] = 14'h1000; m[7] = 14'h3000;
    tbl[1].m = m;
    tbl[1].x = 16'h0100; tbl[1].y = 16'h0200; tbl[1].z = 16'hFF00;
    tbl[1].ex = 16'h0200; tbl[1].ey = 16'h0100; tbl[1].ez = 16'hFF00; tbl[1].es = 1'b0;

    m = '0; m[1] = 14'h3000; m[4] = 14'h1000; m[10] = 14'h1000;
    tbl[2].m = m;
    tbl[2].x = 16'h0100; tbl[2].y = 16'h0000; tbl[2].z = 16'h0000;
    tbl[2].ex = 16'h0000; tbl[2].ey = 16'h0100; tbl[2].ez = 16'h0000; tbl[2].es = 1'b0;

    m = '0; m[0] = 14'h1FFF;
    tbl[3].m = m;
    tbl[3].x = 16'h7000; tbl[3].y = 16'h0000; tbl[3].z = 16'h0000;
    tbl[3].ex = 16'h7FFF; tbl[3].ey = 16'h0000; tbl[3].ez = 16'h0000; tbl[3].es = 1'b1;

    m = '0; m[0] = 14'h2000;
    tbl[4].m = m;
    tbl[4].x = 16'h7000; tbl[4].y = 16'h0000; tbl[4].z = 16'h0000;
    tbl[4].ex = 16'h8000; tbl[4].ey = 16'h0000; tbl[4].ez = 16'h0000; tbl[4].es = 1'b1;

    m = '0; m[0] = 14'h3FFF;
    tbl[5].m = m;
    tbl[5].x = 16'h0001; tbl[5].y = 16'h0000; tbl[5].z = 16'h0000;
    tbl[5].ex = 16'hFFFF; tbl[5].ey = 16'h0000; tbl[5].ez = 16'h0000; tbl[5].es = 1'b0;

    // Reset, with in_valid high to show reset wins.
    rst = 1'b1;
    bus.matrix = ident();
    bus.vx = 16'h0100; bus.vy = 16'h0200; bus.vz = 16'h0300;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(state), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_outputs", 64'({bus.ox, bus.oy, bus.oz, bus.sat}), 64'd0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Table vectors back to back: also checks the 14-cycle accept interval.
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].m, tbl[i].x, tbl[i].y, tbl[i].z, {tbl[i].ex, tbl[i].ey, tbl[i].ez, tbl[i].es});
      if (i > 0) check("accept_interval", 64'(acc_cyc - prev), 64'd14);
      prev = acc_cyc;
      collect(0);
    end

    // Random vectors against the reference model.
    for (int k = 0; k < 4; k++) begin
      logic [15:0] x, y, z;
      for (int i = 0; i < 16; i++) m[i] = 14'($urandom_range(0, 16383));
      x = 16'($urandom_range(0, 65535));
      y = 16'($urandom_range(0, 65535));
      z = 16'($urandom_range(0, 65535));
      send(m, x, y, z, model(m, x, y, z));
      collect(0);
    end

    // Backpressure: out_ready low for 5 cycles in DONE.
    send(tbl[1].m, tbl[1].x, tbl[1].y, tbl[1].z, {tbl[1].ex, tbl[1].ey, tbl[1].ez, tbl[1].es});
    collect(5);

    // Reset on the 6th MAC cycle abandons the vertex.
    send(tbl[3].m, tbl[3].x, tbl[3].y, tbl[3].z, {tbl[3].ex, tbl[3].ey, tbl[3].ez, tbl[3].es});
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("midrst_state", 64'(state), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_outputs", 64'({bus.ox, bus.oy, bus.oz, bus.sat}), 64'd0);
    begin
      int seen = 0;
      for (int t = 0; t < 16; t++) begin
        if (bus.out_valid) seen++;
        @(negedge clk);
      end
      check("midrst_no_output", 64'(seen), 64'd0);
    end
    send(tbl[0].m, tbl[0].x, tbl[0].y, tbl[0].z, {tbl[0].ex, tbl[0].ey, tbl[0].ez, tbl[0].es});
    collect(0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
